// File: rtl/hp_axi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hp_axi_pkg
//  Description : Shared AXI4 encodings and FSM state types for the HP-port
//                RAM responder (burst types, response codes, beat size).
//  Revision    : 1.0 - initial release
// ============================================================================
package hp_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Only full-width 16-byte beats are served.
    localparam logic [2:0] SIZE_16B    = 3'b100;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_t;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // A burst is rejected as a whole when its size or type is unsupported.
    function automatic logic burst_illegal(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_16B) || ((burst != BURST_FIXED) && (burst != BURST_INCR));
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : axi_skid_buf
//  Description : Two-entry valid/ready buffer. Output is driven straight from
//                a register so it holds steady while the sink stalls; two
//                entries let the producer stream at one item per cycle.
//  Ports       : clk, rstn      - clock, async active-low reset
//                i_valid/o_ready/i_data  - upstream side
//                o_valid/i_ready/o_data  - downstream side
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_skid_buf #(
    parameter int WIDTH = 131
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_buf [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_cnt;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_cnt != 2'd2);
    assign o_valid = (r_cnt != 2'd0);
    assign o_data  = r_buf[r_rptr];
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (w_push) begin
                r_buf[r_wptr] <= i_data;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/hp_axi_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : hp_axi_ram_responder
//  Description : AXI4 slave for the 128b/48b HP port backed by an inferred
//                simple dual-port RAM. Independent write and read engines,
//                one burst in flight per direction. Out-of-range beats and
//                unsupported size/burst return SLVERR.
//  Ports       : clk, rstn                         - clock, async active-low reset
//                hp_aw*/hp_w*/hp_b*                - AXI write address/data/response
//                hp_ar*/hp_r*                      - AXI read address/data
//  Revision    : 1.0 - initial release
// ============================================================================
module hp_axi_ram_responder
    import hp_axi_pkg::*;
#(
    parameter int                       HP_ADDR_WIDTH = 48,
    parameter int                       HP_DATA_WIDTH = 128,
    parameter logic [HP_ADDR_WIDTH-1:0] BASE_ADDR     = 48'h0,
    parameter int                       DEPTH         = 1024
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [HP_ADDR_WIDTH-1:0]   hp_awaddr,
    input  logic [7:0]                 hp_awlen,
    input  logic [2:0]                 hp_awsize,
    input  logic [1:0]                 hp_awburst,
    input  logic                       hp_awvalid,
    output logic                       hp_awready,
    input  logic [HP_DATA_WIDTH-1:0]   hp_wdata,
    input  logic [HP_DATA_WIDTH/8-1:0] hp_wstrb,
    input  logic                       hp_wlast,
    input  logic                       hp_wvalid,
    output logic                       hp_wready,
    output logic [1:0]                 hp_bresp,
    output logic                       hp_bvalid,
    input  logic                       hp_bready,
    input  logic [HP_ADDR_WIDTH-1:0]   hp_araddr,
    input  logic [7:0]                 hp_arlen,
    input  logic [2:0]                 hp_arsize,
    input  logic [1:0]                 hp_arburst,
    input  logic                       hp_arvalid,
    output logic                       hp_arready,
    output logic [HP_DATA_WIDTH-1:0]   hp_rdata,
    output logic [1:0]                 hp_rresp,
    output logic                       hp_rlast,
    output logic                       hp_rvalid,
    input  logic                       hp_rready
);

    localparam int c_STRB_W = HP_DATA_WIDTH / 8;
    // Word index of (addr - BASE) carries a sign bit plus one bit of headroom
    // so an INCR burst near the top of the address space cannot alias.
    localparam int c_IDX_W  = HP_ADDR_WIDTH - 2;
    localparam int c_RAM_AW = $clog2(DEPTH);
    localparam int c_BUF_W  = HP_DATA_WIDTH + 3;
    localparam logic [c_IDX_W-1:0] c_DEPTH_IDX = c_IDX_W'(DEPTH);

    function automatic logic [c_IDX_W-1:0] start_idx(input logic [HP_ADDR_WIDTH-1:0] addr);
        return {2'b00, addr[HP_ADDR_WIDTH-1:4]} - {2'b00, BASE_ADDR[HP_ADDR_WIDTH-1:4]};
    endfunction

    function automatic logic in_ram(input logic [c_IDX_W-1:0] idx);
        return !idx[c_IDX_W-1] && (idx < c_DEPTH_IDX);
    endfunction

    // Ready outputs are held low until the first edge after reset release.
    logic r_out_en;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_out_en <= 1'b0;
        else       r_out_en <= 1'b1;
    end

    // ------------------------------------------------------------------ write
    w_state_t             r_w_state, w_w_next;
    logic [c_IDX_W-1:0]   r_aw_idx;
    logic [7:0]           r_aw_len;
    logic                 r_aw_fixed;
    logic                 r_aw_bad;
    logic [7:0]           r_w_cnt;
    logic                 r_w_err;
    logic                 w_aw_hs;
    logic                 w_w_hs;
    logic                 w_w_final;
    logic                 w_mem_we;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_w_state <= W_IDLE;
        else       r_w_state <= w_w_next;
    end

    always_comb begin
        w_w_next   = r_w_state;
        hp_awready = 1'b0;
        hp_wready  = 1'b0;
        hp_bvalid  = 1'b0;
        hp_bresp   = RESP_OKAY;
        case (r_w_state)
            W_IDLE: begin
                hp_awready = r_out_en;
                if (r_out_en && hp_awvalid) w_w_next = W_DATA;
            end
            W_DATA: begin
                hp_wready = 1'b1;
                if (hp_wvalid && w_w_final) w_w_next = W_RESP;
            end
            W_RESP: begin
                hp_bvalid = 1'b1;
                hp_bresp  = r_w_err ? RESP_SLVERR : RESP_OKAY;
                if (hp_bready) w_w_next = W_IDLE;
            end
            default: w_w_next = W_IDLE;
        endcase
    end

    assign w_aw_hs   = hp_awvalid && hp_awready;
    assign w_w_hs    = hp_wvalid && hp_wready;
    assign w_w_final = (r_w_cnt == r_aw_len);
    assign w_mem_we  = w_w_hs && !r_aw_bad && in_ram(r_aw_idx);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_aw_idx   <= '0;
            r_aw_len   <= '0;
            r_aw_fixed <= 1'b0;
            r_aw_bad   <= 1'b0;
            r_w_cnt    <= '0;
            r_w_err    <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_idx   <= start_idx(hp_awaddr);
            r_aw_len   <= hp_awlen;
            r_aw_fixed <= (hp_awburst == BURST_FIXED);
            r_aw_bad   <= burst_illegal(hp_awsize, hp_awburst);
            r_w_cnt    <= '0;
            r_w_err    <= burst_illegal(hp_awsize, hp_awburst);
        end else if (w_w_hs) begin
            r_w_cnt <= r_w_cnt + 8'd1;
            if (!r_aw_fixed) r_aw_idx <= r_aw_idx + 1'b1;
            // Mis-placed wlast flags the response; beat count still follows awlen.
            if (!in_ram(r_aw_idx) || (hp_wlast != w_w_final)) r_w_err <= 1'b1;
        end
    end

    // -------------------------------------------------------------------- RAM
    logic [HP_DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [HP_DATA_WIDTH-1:0] r_rd_q;
    logic [c_IDX_W-1:0]       r_ar_idx;
    logic                     w_rd_issue;

    // Write and read live in separate processes; a same-word collision
    // therefore returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (hp_wstrb[b]) r_mem[r_aw_idx[c_RAM_AW-1:0]][b*8 +: 8] <= hp_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_issue) r_rd_q <= r_mem[r_ar_idx[c_RAM_AW-1:0]];
    end

    // ------------------------------------------------------------------- read
    r_state_t             r_r_state, w_r_next;
    logic [7:0]           r_ar_len;
    logic                 r_ar_fixed;
    logic                 r_ar_bad;
    logic [7:0]           r_r_cnt;
    logic                 r_r_done;
    logic                 r_st_valid;
    logic                 r_st_err;
    logic                 r_st_last;
    logic                 w_ar_hs;
    logic                 w_st_adv;
    logic                 w_buf_ready;
    logic [c_BUF_W-1:0]   w_st_data;
    logic [c_BUF_W-1:0]   w_r_out;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_r_state <= R_IDLE;
        else       r_r_state <= w_r_next;
    end

    always_comb begin
        w_r_next   = r_r_state;
        hp_arready = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                hp_arready = r_out_en;
                if (r_out_en && hp_arvalid) w_r_next = R_DATA;
            end
            R_DATA: begin
                if (hp_rvalid && hp_rready && hp_rlast) w_r_next = R_IDLE;
            end
            default: w_r_next = R_IDLE;
        endcase
    end

    assign w_ar_hs    = hp_arvalid && hp_arready;
    // The RAM output stage moves on when empty or when the buffer takes it.
    assign w_st_adv   = !r_st_valid || w_buf_ready;
    assign w_rd_issue = (r_r_state == R_DATA) && !r_r_done && w_st_adv;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ar_idx   <= '0;
            r_ar_len   <= '0;
            r_ar_fixed <= 1'b0;
            r_ar_bad   <= 1'b0;
            r_r_cnt    <= '0;
            r_r_done   <= 1'b0;
            r_st_valid <= 1'b0;
            r_st_err   <= 1'b0;
            r_st_last  <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_ar_idx   <= start_idx(hp_araddr);
                r_ar_len   <= hp_arlen;
                r_ar_fixed <= (hp_arburst == BURST_FIXED);
                r_ar_bad   <= burst_illegal(hp_arsize, hp_arburst);
                r_r_cnt    <= '0;
                r_r_done   <= 1'b0;
            end else if (w_rd_issue) begin
                r_r_cnt <= r_r_cnt + 8'd1;
                if (!r_ar_fixed) r_ar_idx <= r_ar_idx + 1'b1;
                if (r_r_cnt == r_ar_len) r_r_done <= 1'b1;
            end
            if (w_st_adv) r_st_valid <= w_rd_issue;
            if (w_rd_issue) begin
                r_st_err  <= r_ar_bad || !in_ram(r_ar_idx);
                r_st_last <= (r_r_cnt == r_ar_len);
            end
        end
    end

    assign w_st_data = {r_st_err ? {HP_DATA_WIDTH{1'b0}} : r_rd_q,
                        r_st_err ? RESP_SLVERR : RESP_OKAY,
                        r_st_last};

    axi_skid_buf #(
        .WIDTH (c_BUF_W)
    ) u_r_skid (
        .clk     (clk),
        .rstn    (rstn),
        .i_valid (r_st_valid),
        .o_ready (w_buf_ready),
        .i_data  (w_st_data),
        .o_valid (hp_rvalid),
        .i_ready (hp_rready),
        .o_data  (w_r_out)
    );

    assign {hp_rdata, hp_rresp, hp_rlast} = w_r_out;

endmodule
`default_nettype wire
